// File: rtl/ws_tile_scheduler.sv
// Walks an N x K grid of PE-array-sized GEMM tiles (N outer, K inner), issuing one
// go pulse per tile to the weight-stationary array controller and waiting for its done.
module ws_tile_scheduler #(
  parameter int ARRAY_ROWS = 3,
  parameter int ARRAY_COLS = 3,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_n_tiles,
  input  logic [CNT_W-1:0]  num_k_tiles,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [ADDR_W-1:0] iact_base,
  input  logic [ADDR_W-1:0] psum_base,
  input  logic              ctrl_done,
  output logic              ctrl_go,
  output logic [ADDR_W-1:0] tile_weight_addr,
  output logic [ADDR_W-1:0] tile_iact_addr,
  output logic [ADDR_W-1:0] tile_psum_addr,
  output logic              accumulate,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;

  // Weight and psum tiles are R x C words; iact tiles are R x R words.
  localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(ARRAY_ROWS * ARRAY_COLS);
  localparam logic [ADDR_W-1:0] I_STEP = ADDR_W'(ARRAY_ROWS * ARRAY_ROWS);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_num_n;
  logic [CNT_W-1:0]  r_num_k;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_k;
  logic [ADDR_W-1:0] r_iact_base;
  logic [ADDR_W-1:0] r_weight;
  logic [ADDR_W-1:0] r_iact;
  logic [ADDR_W-1:0] r_psum;
  logic              r_acc;
  logic              r_go;
  logic              r_done;
  logic              r_err;
  logic              r_busy;

  logic w_last_k;
  logic w_last_n;
  logic w_zero_cnt;

  // Counts are known non-zero once latched, so count-1 cannot underflow.
  assign w_last_k   = (r_k == r_num_k - CNT_W'(1));
  assign w_last_n   = (r_n == r_num_n - CNT_W'(1));
  assign w_zero_cnt = (num_n_tiles == '0) || (num_k_tiles == '0);

  // NOTE: every register here is updated with non-blocking assignments so all
  // state advances together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_num_n     <= '0;
      r_num_k     <= '0;
      r_n         <= '0;
      r_k         <= '0;
      r_iact_base <= '0;
      r_weight    <= '0;
      r_iact      <= '0;
      r_psum      <= '0;
      r_acc       <= 1'b0;
      r_go        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_go   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_zero_cnt) begin
                r_err <= 1'b1;
              end else begin
                r_num_n     <= num_n_tiles;
                r_num_k     <= num_k_tiles;
                r_n         <= '0;
                r_k         <= '0;
                r_iact_base <= iact_base;
                r_weight    <= weight_base;
                r_iact      <= iact_base;
                r_psum      <= psum_base;
                r_acc       <= 1'b0;
                r_go        <= 1'b1;
                r_busy      <= 1'b1;
                r_state     <= S_ISSUE;
              end
            end
          end
          // The controller's done is still high from the previous tile here.
          S_ISSUE: r_state <= S_WAIT;
          S_WAIT: begin
            if (ctrl_done) r_state <= S_ADVANCE;
          end
          S_ADVANCE: begin
            if (!w_last_k) begin
              r_k      <= r_k + CNT_W'(1);
              r_weight <= r_weight + W_STEP;
              r_iact   <= r_iact + I_STEP;
              r_acc    <= 1'b1;
              r_go     <= 1'b1;
              r_state  <= S_ISSUE;
            end else if (!w_last_n) begin
              r_n      <= r_n + CNT_W'(1);
              r_k      <= '0;
              r_weight <= r_weight + W_STEP;
              r_iact   <= r_iact_base;
              r_psum   <= r_psum + W_STEP;
              r_acc    <= 1'b0;
              r_go     <= 1'b1;
              r_state  <= S_ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
          S_FIN: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ctrl_go          = r_go;
  assign tile_weight_addr = r_weight;
  assign tile_iact_addr   = r_iact;
  assign tile_psum_addr   = r_psum;
  assign accumulate       = r_acc;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;

endmodule

// File: tb/tb_ws_tile_scheduler.sv
// Scoreboard bench for ws_tile_scheduler: stimulus queues expected go/done/err events
// with their cycle stamps; a negedge monitor pops and compares as the DUT emits them.
module tb_ws_tile_scheduler;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;
  localparam int DLY    = 5;  // controller latency: go in cycle g -> ctrl_done high in g+DLY

  typedef enum logic [1:0] {EV_GO, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t          kind;
    int unsigned       cyc;
    logic [ADDR_W-1:0] w;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] p;
    logic              acc;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_n_tiles;
  logic [CNT_W-1:0]  num_k_tiles;
  logic [ADDR_W-1:0] weight_base;
  logic [ADDR_W-1:0] iact_base;
  logic [ADDR_W-1:0] psum_base;
  logic              ctrl_done;
  logic              ctrl_go;
  logic [ADDR_W-1:0] tile_weight_addr;
  logic [ADDR_W-1:0] tile_iact_addr;
  logic [ADDR_W-1:0] tile_psum_addr;
  logic              accumulate;
  logic              busy;
  logic              done;
  logic              err;

  ws_tile_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .num_n_tiles      (num_n_tiles),
    .num_k_tiles      (num_k_tiles),
    .weight_base      (weight_base),
    .iact_base        (iact_base),
    .psum_base        (psum_base),
    .ctrl_done        (ctrl_done),
    .ctrl_go          (ctrl_go),
    .tile_weight_addr (tile_weight_addr),
    .tile_iact_addr   (tile_iact_addr),
    .tile_psum_addr   (tile_psum_addr),
    .accumulate       (accumulate),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_go(input int unsigned c, input logic [ADDR_W-1:0] w,
                         input logic [ADDR_W-1:0] i, input logic [ADDR_W-1:0] p,
                         input logic acc);
    ev_t e;
    e.kind = EV_GO; e.cyc = c; e.w = w; e.i = i; e.p = p; e.acc = acc;
    sb_q.push_back(e);
  endtask

  task automatic push_ev(input ev_kind_t k, input int unsigned c);
    ev_t e;
    e.kind = k; e.cyc = c; e.w = '0; e.i = '0; e.p = '0; e.acc = 1'b0;
    sb_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ctrl_go || done || err)) begin
      ev_t      e;
      ev_kind_t k;
      k = ctrl_go ? EV_GO : (done ? EV_DONE : EV_ERR);
      if (sb_q.size() == 0) begin
        check("unexpected_event", 64'(k) + 64'h10, 64'h0);
      end else begin
        e = sb_q.pop_front();
        check("event_kind", 64'(k), 64'(e.kind));
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        if (e.kind == EV_GO) begin
          check("go_weight_addr", 64'(tile_weight_addr), 64'(e.w));
          check("go_iact_addr", 64'(tile_iact_addr), 64'(e.i));
          check("go_psum_addr", 64'(tile_psum_addr), 64'(e.p));
          check("go_accumulate", 64'(accumulate), 64'(e.acc));
          check("go_busy", 64'(busy), 64'h1);
        end
      end
    end
  end

  // Array controller model: done is a level, dropped after go and raised DLY cycles later.
  initial begin
    ctrl_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ctrl_go === 1'b1) begin
        @(posedge clk); #1;
        ctrl_done = 1'b0;
        repeat (DLY - 1) @(posedge clk);
        #1;
        ctrl_done = 1'b1;
      end
    end
  end

  task automatic run_start(input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] k,
                           input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ib,
                           input logic [ADDR_W-1:0] pb, output int unsigned s);
    @(posedge clk); #1;
    num_n_tiles = n; num_k_tiles = k;
    weight_base = wb; iact_base = ib; psum_base = pb;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (sb_q.size() != 0 && b < 400) begin
      @(posedge clk); #1;
      b++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, 64'(sb_q.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;
    logic [ADDR_W-1:0] t2_w [6];
    logic [ADDR_W-1:0] t2_i [6];
    logic [ADDR_W-1:0] t2_p [6];
    logic              t2_a [6];

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_n_tiles = '0; num_k_tiles = '0;
    weight_base = '0; iact_base = '0; psum_base = '0;
    #1;
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_go", 64'(ctrl_go), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_err", 64'(err), 64'h0);
    check("reset_weight", 64'(tile_weight_addr), 64'h0);
    check("reset_iact", 64'(tile_iact_addr), 64'h0);
    check("reset_psum", 64'(tile_psum_addr), 64'h0);
    check("reset_acc", 64'(accumulate), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single tile; inputs scrambled after start must not matter.
    run_start(8'd1, 8'd1, 32'h100, 32'h200, 32'h300, s);
    push_go(s + 1, 32'h100, 32'h200, 32'h300, 1'b0);
    push_ev(EV_DONE, s + 8);
    weight_base = 32'hDEAD_0000; iact_base = 32'hBEEF_0000; num_k_tiles = 8'd9;
    drain("t1_drain");

    // 2: N=2, K=3 from zero bases.
    t2_w = '{32'd0, 32'd9, 32'd18, 32'd27, 32'd36, 32'd45};
    t2_i = '{32'd0, 32'd9, 32'd18, 32'd0, 32'd9, 32'd18};
    t2_p = '{32'd0, 32'd0, 32'd0, 32'd9, 32'd9, 32'd9};
    t2_a = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    run_start(8'd2, 8'd3, 32'h0, 32'h0, 32'h0, s);
    for (int j = 0; j < 6; j++)
      push_go(s + 1 + 7 * j, t2_w[j], t2_i[j], t2_p[j], t2_a[j]);
    push_ev(EV_DONE, s + 43);
    check("t2_busy_running", 64'(busy), 64'h1);
    drain("t2_drain");
    check("t2_busy_after", 64'(busy), 64'h0);

    // 3: zero k count is rejected.
    run_start(8'd2, 8'd0, 32'h40, 32'h50, 32'h60, s);
    push_ev(EV_ERR, s + 1);
    check("t3_busy_err_cycle", 64'(busy), 64'h0);
    drain("t3_drain");
    check("t3_busy_after", 64'(busy), 64'h0);

    // 4: abort during WAIT of the second tile, then a fresh full run.
    run_start(8'd1, 8'd4, 32'h40, 32'h80, 32'hC0, s);
    push_go(s + 1, 32'h40, 32'h80, 32'hC0, 1'b0);
    push_go(s + 8, 32'h49, 32'h89, 32'hC0, 1'b1);
    wait_cycle(s + 10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t4_busy_after_abort", 64'(busy), 64'h0);
    check("t4_go_after_abort", 64'(ctrl_go), 64'h0);
    drain("t4_abort_drain");
    repeat (10) @(posedge clk);
    #1;
    run_start(8'd1, 8'd4, 32'h40, 32'h80, 32'hC0, s);
    push_go(s + 1,  32'h40, 32'h80, 32'hC0, 1'b0);
    push_go(s + 8,  32'h49, 32'h89, 32'hC0, 1'b1);
    push_go(s + 15, 32'h52, 32'h92, 32'hC0, 1'b1);
    push_go(s + 22, 32'h5B, 32'h9B, 32'hC0, 1'b1);
    push_ev(EV_DONE, s + 29);
    drain("t4_rerun_drain");

    // 5: start while busy (with a zero count) is ignored entirely.
    run_start(8'd1, 8'd2, 32'h1000, 32'h2000, 32'h3000, s);
    push_go(s + 1, 32'h1000, 32'h2000, 32'h3000, 1'b0);
    push_go(s + 8, 32'h1009, 32'h2009, 32'h3000, 1'b1);
    push_ev(EV_DONE, s + 15);
    wait_cycle(s + 4);
    num_n_tiles = 8'd5; num_k_tiles = 8'd0;
    weight_base = 32'hAAAA_0000; iact_base = 32'hBBBB_0000; psum_base = 32'hCCCC_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain("t5_drain");

    // 6: weight pointer wraps; ctrl_done is still high in each ISSUE cycle.
    run_start(8'd1, 8'd2, 32'hFFFF_FFFC, 32'h10, 32'h20, s);
    check("t6_stale_done_in_issue", 64'(ctrl_done), 64'h1);
    push_go(s + 1, 32'hFFFF_FFFC, 32'h10, 32'h20, 1'b0);
    push_go(s + 8, 32'h0000_0005, 32'h19, 32'h20, 1'b1);
    push_ev(EV_DONE, s + 15);
    drain("t6_drain");

    // Async reset mid-run returns to reset values immediately.
    run_start(8'd1, 8'd3, 32'h500, 32'h600, 32'h700, s);
    push_go(s + 1, 32'h500, 32'h600, 32'h700, 1'b0);
    wait_cycle(s + 3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_weight", 64'(tile_weight_addr), 64'h0);
    check("rst_psum", 64'(tile_psum_addr), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain("rst_drain");
    repeat (10) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(sb_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
